// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the sequenced memory stage.
package mem_stage_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 20;
    localparam int DEF_WB_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_addr_sel.sv
// Combinational select of access address (stack pointer or zero-extended ALU result)
// and store data (PC+1 for push-PC, otherwise the operand).
module mem_addr_sel #(
    parameter int DATA_W = mem_stage_pkg::DEF_DATA_W,
    parameter int ADDR_W = mem_stage_pkg::DEF_ADDR_W
) (
    input  logic                  i_isStack,
    input  logic                  i_isPushPc,
    input  logic [DATA_W-1:0]     i_aluData,
    input  logic [2*DATA_W-1:0]   i_stackData,
    input  logic [2*DATA_W-1:0]   i_pc,
    input  logic [2*DATA_W-1:0]   i_writeData,
    output logic [ADDR_W-1:0]     o_addr,
    output logic [2*DATA_W-1:0]   o_wdata
);

    logic [ADDR_W+DATA_W-1:0] alu_ext;
    logic                     unused_bits;

    assign alu_ext     = {{ADDR_W{1'b0}}, i_aluData};
    assign o_addr      = i_isStack ? i_stackData[ADDR_W-1:0] : alu_ext[ADDR_W-1:0];
    assign o_wdata     = i_isPushPc ? (i_pc + (2*DATA_W)'(1)) : i_writeData;
    assign unused_bits = &{1'b0, i_stackData[2*DATA_W-1:ADDR_W], alu_ext[ADDR_W+DATA_W-1:ADDR_W]};

endmodule

// File: rtl/mem_stage_seq.sv
// Pipeline memory stage driving a narrow req/ack port; 32-bit accesses are split
// into two sequential beats, low half first, and the pipeline stalls while busy.
module mem_stage_seq #(
    parameter int DATA_W = mem_stage_pkg::DEF_DATA_W,
    parameter int ADDR_W = mem_stage_pkg::DEF_ADDR_W,
    parameter int WB_W   = mem_stage_pkg::DEF_WB_W
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic                  i_isStack,
    input  logic                  i_isPushPc,
    input  logic                  i_memRead,
    input  logic                  i_memWrite,
    input  logic                  i_en32,
    input  logic [WB_W-1:0]       i_wb,
    input  logic [DATA_W-1:0]     i_aluData,
    input  logic [2*DATA_W-1:0]   i_stackData,
    input  logic [2*DATA_W-1:0]   i_pc,
    input  logic [2*DATA_W-1:0]   i_writeData,
    output logic                  o_stall,
    output logic                  o_valid,
    output logic [WB_W-1:0]       o_wb,
    output logic [DATA_W-1:0]     o_aluData,
    output logic [2*DATA_W-1:0]   o_memData,
    output logic [ADDR_W-1:0]     o_address,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [DATA_W-1:0]     i_mem_rdata
);
    import mem_stage_pkg::*;

    mem_state_e            state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [2*DATA_W-1:0]   wdata_q, wdata_d;
    logic [WB_W-1:0]       wb_q, wb_d;
    logic [DATA_W-1:0]     alu_q, alu_d;
    logic                  en32_q, en32_d;
    logic                  we_q, we_d;
    logic [DATA_W-1:0]     rd_lo_q, rd_lo_d;

    logic                  stall_q, stall_d;
    logic                  valid_q, valid_d;
    logic [WB_W-1:0]       out_wb_q, out_wb_d;
    logic [DATA_W-1:0]     out_alu_q, out_alu_d;
    logic [2*DATA_W-1:0]   out_mem_q, out_mem_d;
    logic [ADDR_W-1:0]     out_addr_q, out_addr_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;

    logic [ADDR_W-1:0]     sel_addr;
    logic [2*DATA_W-1:0]   sel_wdata;

    mem_addr_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_addr_sel (
        .i_isStack   (i_isStack),
        .i_isPushPc  (i_isPushPc),
        .i_aluData   (i_aluData),
        .i_stackData (i_stackData),
        .i_pc        (i_pc),
        .i_writeData (i_writeData),
        .o_addr      (sel_addr),
        .o_wdata     (sel_wdata)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wb_d        = wb_q;
        alu_d       = alu_q;
        en32_d      = en32_q;
        we_d        = we_q;
        rd_lo_d     = rd_lo_q;
        valid_d     = 1'b0;
        out_wb_d    = out_wb_q;
        out_alu_d   = out_alu_q;
        out_mem_d   = out_mem_q;
        out_addr_d  = out_addr_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if (!i_memRead && !i_memWrite) begin
                        valid_d   = 1'b1;
                        out_wb_d  = i_wb;
                        out_alu_d = i_aluData;
                    end else begin
                        // Write wins when both directions are requested.
                        addr_d      = sel_addr;
                        wdata_d     = sel_wdata;
                        wb_d        = i_wb;
                        alu_d       = i_aluData;
                        en32_d      = i_en32;
                        we_d        = i_memWrite;
                        out_addr_d  = sel_addr;
                        mem_req_d   = 1'b1;
                        mem_we_d    = i_memWrite;
                        mem_addr_d  = sel_addr;
                        mem_wdata_d = sel_wdata[DATA_W-1:0];
                        state_d     = BEAT0;
                    end
                end
            end
            BEAT0: begin
                if (i_mem_ack) begin
                    if (!we_q) begin
                        rd_lo_d = i_mem_rdata;
                    end
                    if (en32_q) begin
                        mem_addr_d  = addr_q + ADDR_W'(1);
                        mem_wdata_d = wdata_q[2*DATA_W-1:DATA_W];
                        state_d     = BEAT1;
                    end else begin
                        valid_d     = 1'b1;
                        out_wb_d    = wb_q;
                        out_alu_d   = alu_q;
                        if (!we_q) begin
                            out_mem_d = {{DATA_W{1'b0}}, i_mem_rdata};
                        end
                        mem_req_d   = 1'b0;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = '0;
                        mem_wdata_d = '0;
                        state_d     = IDLE;
                    end
                end
            end
            BEAT1: begin
                if (i_mem_ack) begin
                    valid_d     = 1'b1;
                    out_wb_d    = wb_q;
                    out_alu_d   = alu_q;
                    if (!we_q) begin
                        out_mem_d = {i_mem_rdata, rd_lo_q};
                    end
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        stall_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wb_q        <= '0;
            alu_q       <= '0;
            en32_q      <= 1'b0;
            we_q        <= 1'b0;
            rd_lo_q     <= '0;
            stall_q     <= 1'b0;
            valid_q     <= 1'b0;
            out_wb_q    <= '0;
            out_alu_q   <= '0;
            out_mem_q   <= '0;
            out_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wb_q        <= wb_d;
            alu_q       <= alu_d;
            en32_q      <= en32_d;
            we_q        <= we_d;
            rd_lo_q     <= rd_lo_d;
            stall_q     <= stall_d;
            valid_q     <= valid_d;
            out_wb_q    <= out_wb_d;
            out_alu_q   <= out_alu_d;
            out_mem_q   <= out_mem_d;
            out_addr_q  <= out_addr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign o_stall     = stall_q;
    assign o_valid     = valid_q;
    assign o_wb        = out_wb_q;
    assign o_aluData   = out_alu_q;
    assign o_memData   = out_mem_q;
    assign o_address   = out_addr_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;

endmodule
